map_port_arbiter: RTL and testbench
===================================

// Module: map_port_arbiter
// PURPOSE
//  Shares port B of the 32x36-tile map/candy BRAM between several requesters
//  (pacman tile lookup, four ghost tile lookups, cookie-eaten tile clear).
//  Per-cycle arbitration: writes take priority with a bounded streak, reads
//  are served round-robin. Responses are returned tagged with requester id.
//  Sits between the movement/cookie logic and the dual-port map BRAM in pacman_game.
// PARAMETERS
//  N_REQ          6    number of requesters (index 0 = pacman, 1-4 ghosts, 5 cookie writer)
//  ADDR_W         11   BRAM address width (32*36 = 1152 tiles)
//  DATA_W         4    tile code width
//  MAX_WR_STREAK  2    max consecutive write grants while any read is pending
// PORTS
//  vga_pix_clk  in   1               clock
//  rst          in   1               synchronous, active-high reset
//  req          in   N_REQ           per-requester access request
//  req_we       in   N_REQ           1 = write, 0 = read (qualified by req)
//  req_addr     in   N_REQ*ADDR_W    packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_wdata    in   N_REQ*DATA_W    packed write data
//  gnt          out  N_REQ           one-hot grant, 1-cycle pulse
//  mem_addr     out  ADDR_W          to BRAM addrb (registered)
//  mem_we       out  1               to BRAM web (registered)
//  mem_wdata    out  DATA_W          to BRAM dib (registered)
//  mem_rdata    in   DATA_W          from BRAM doutb (1-cycle synchronous read)
//  rsp_valid    out  1               read data valid, 1-cycle pulse
//  rsp_id       out  $clog2(N_REQ)   requester index owning rsp_data
//  rsp_data     out  DATA_W          = mem_rdata, valid only while rsp_valid
// BEHAVIOUR
//  Reset: gnt=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_id=0,
//   rr_ptr=0, wr_streak=0; in-flight reads dropped (no rsp after reset).
//  Arbitration at each edge E0 over the req sampled at E0:
//   - W = req & req_we, R = req & ~req_we.
//   - If W!=0 and (R==0 or wr_streak<MAX_WR_STREAK): grant lowest-index bit of W;
//     wr_streak <= (R!=0) ? wr_streak+1 : 0; rr_ptr unchanged.
//   - Else if R!=0: grant first set bit of R at/after rr_ptr (wrapping N_REQ-1 -> 0);
//     rr_ptr <= winner+1 mod N_REQ; wr_streak <= 0.
//   - Else: no grant; gnt=0, mem_we=0; rr_ptr and wr_streak hold.
//  Registered at E0: gnt one-hot; mem_addr/mem_we/mem_wdata from winner.
//   gnt is high for exactly the cycle after E0. A requester wanting one access
//   drops req in that cycle; req still high at the next edge = new access.
//  Read latency: BRAM samples mem_addr at E1, data on mem_rdata after E1.
//   rsp_valid/rsp_id registered at E1 (pipelined from grant stage); rsp_data is
//   combinational mem_rdata. rsp_valid high in cycle after E1 = 2 cycles after req edge.
//  Writes produce no response. Throughput: one access per cycle, back-to-back.
//  Read-after-write same address: write granted at E0, read granted at E0+1
//   returns the new data (BRAM write-first not required; sequential ordering suffices).
//  Simultaneous read+write from same requester index impossible (single req bit).
//  Out-of-range addresses (>=1152) passed through unchanged; not checked.
//  rst asserted mid-operation: next cycle all outputs at reset values.
// TESTING
//  1 single read: req[0]=1,addr=33 one cycle, BRAM[33]=4'h2 -> gnt=6'b000001
//    next cycle, mem_addr=33, rsp_valid=1 rsp_id=0 rsp_data=2 two cycles after req.
//  2 round-robin: req=6'b011110 held reads -> grants 1,2,3,4,1,2..., one per cycle;
//    rsp_id sequence matches grant order, 2-cycle lag.
//  3 write priority: req[5] write addr=70 data=empty_tile + req[0] read addr=70 same
//    edge -> write granted first, read next cycle, rsp_data=empty_tile.
//  4 streak bound: req[5] write held + req[2] read held, MAX_WR_STREAK=2 ->
//    grants 5,5,2,5,5,2...
//  5 idle: req=0 for 10 cycles -> gnt=0, mem_we=0, rsp_valid=0, rr_ptr unchanged.
//  6 reset mid-flight: read granted, rst=1 at following edge -> rsp_valid stays 0,
//    gnt=0, next read after rst release granted to requester 0 first (rr_ptr=0).

Source files
------------

// File: rtl/map_port_arbiter.sv
// -----------------------------------------------------------------------------
// map_port_arbiter
// Lets several requesters share port B of the 32x36-tile map/candy BRAM:
// the pacman tile lookup (0), the four ghost tile lookups (1-4) and the
// cookie-eaten tile clear (5). At most one access is granted per cycle.
// Writes win by default. While any read is waiting, though, at most
// MAX_WR_STREAK writes in a row are granted before a read gets a turn.
// Reads are served round-robin. Each read response carries the index of the
// requester that issued it.
//
// Ports
//   vga_pix_clk  clock
//   rst          synchronous, active-high reset
//   req          per-requester access request
//   req_we       per-requester direction (1 = write, 0 = read)
//   req_addr     packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata    packed write data, requester i at [i*DATA_W +: DATA_W]
//   gnt          one-hot grant, high for the single cycle after the decision
//   mem_addr     registered BRAM port-B address
//   mem_we       registered BRAM port-B write enable
//   mem_wdata    registered BRAM port-B write data
//   mem_rdata    BRAM port-B read data (one-cycle synchronous read)
//   rsp_valid    read response strobe, two cycles after the request edge
//   rsp_id       requester that owns rsp_data
//   rsp_data     read data, meaningful only while rsp_valid is high
// -----------------------------------------------------------------------------
module map_port_arbiter #(
   parameter int N_REQ         = 6,
   parameter int ADDR_W        = 11,
   parameter int DATA_W        = 4,
   parameter int MAX_WR_STREAK = 2,
   localparam int ID_W         = $clog2(N_REQ)
) (
   input  logic                       vga_pix_clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           req_we,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W-1:0]    req_wdata,
   output logic [N_REQ-1:0]           gnt,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic                       mem_we,
   output logic [DATA_W-1:0]          mem_wdata,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic                       rsp_valid,
   output logic [ID_W-1:0]            rsp_id,
   output logic [DATA_W-1:0]          rsp_data
);

   localparam int                   STREAK_W   = $clog2(MAX_WR_STREAK + 1);
   localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_WR_STREAK);
   localparam logic [STREAK_W-1:0]  STREAK_ONE = {{(STREAK_W-1){1'b0}}, 1'b1};
   localparam logic [ID_W-1:0]      ID_LAST    = ID_W'(N_REQ - 1);
   localparam logic [ID_W-1:0]      ID_ONE     = {{(ID_W-1){1'b0}}, 1'b1};
   localparam logic [N_REQ-1:0]     GNT_ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [N_REQ-1:0]    wr_set_s;
   logic [N_REQ-1:0]    rd_set_s;
   logic [N_REQ-1:0]    rd_mask_s;
   logic [N_REQ-1:0]    rd_hi_s;
   logic [N_REQ-1:0]    rd_pick_s;
   logic [ID_W-1:0]     wr_idx_s;
   logic [ID_W-1:0]     rd_idx_s;
   logic [ID_W-1:0]     rr_next_s;
   logic                rd_any_s;
   logic                wr_win_s;

   logic [ID_W-1:0]     rr_ptr_r;
   logic [STREAK_W-1:0] wr_streak_r;
   logic                rd_pend_r;
   logic [ID_W-1:0]     rd_id_r;

   assign wr_set_s = req & req_we;
   assign rd_set_s = req & ~req_we;
   assign rd_any_s = |rd_set_s;

   // A write wins unless reads are waiting and the write streak is used up.
   assign wr_win_s = (|wr_set_s) && (!rd_any_s || (wr_streak_r < STREAK_MAX));

   // Priority encoder: the lowest-index write requester wins.
   always_comb begin
      wr_idx_s = {ID_W{1'b0}};
      for (int i = N_REQ - 1; i >= 0; i--) begin
         wr_idx_s = wr_set_s[i] ? ID_W'(i) : wr_idx_s;
      end
   end

   // Round-robin read pick: first try the readers at or above rr_ptr, then wrap to the lowest reader.
   always_comb begin
      rd_mask_s = {N_REQ{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         rd_mask_s[i] = (ID_W'(i) >= rr_ptr_r);
      end
      rd_hi_s   = rd_set_s & rd_mask_s;
      rd_pick_s = (|rd_hi_s) ? rd_hi_s : rd_set_s;
      rd_idx_s  = {ID_W{1'b0}};
      for (int i = N_REQ - 1; i >= 0; i--) begin
         rd_idx_s = rd_pick_s[i] ? ID_W'(i) : rd_idx_s;
      end
      rr_next_s = (rd_idx_s == ID_LAST) ? {ID_W{1'b0}} : (rd_idx_s + ID_ONE);
   end

   // Grant stage: register the winner's access onto BRAM port B and update the fairness state.
   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         gnt         <= {N_REQ{1'b0}};
         mem_addr    <= {ADDR_W{1'b0}};
         mem_we      <= 1'b0;
         mem_wdata   <= {DATA_W{1'b0}};
         rr_ptr_r    <= {ID_W{1'b0}};
         wr_streak_r <= {STREAK_W{1'b0}};
         rd_pend_r   <= 1'b0;
         rd_id_r     <= {ID_W{1'b0}};
      end else if (wr_win_s) begin
         gnt         <= GNT_ONE << wr_idx_s;
         mem_addr    <= req_addr[wr_idx_s*ADDR_W +: ADDR_W];
         mem_we      <= 1'b1;
         mem_wdata   <= req_wdata[wr_idx_s*DATA_W +: DATA_W];
         // The streak only counts writes that made a read wait.
         wr_streak_r <= rd_any_s ? (wr_streak_r + STREAK_ONE) : {STREAK_W{1'b0}};
         rd_pend_r   <= 1'b0;
      end else if (rd_any_s) begin
         gnt         <= GNT_ONE << rd_idx_s;
         mem_addr    <= req_addr[rd_idx_s*ADDR_W +: ADDR_W];
         mem_we      <= 1'b0;
         rr_ptr_r    <= rr_next_s;
         wr_streak_r <= {STREAK_W{1'b0}};
         rd_pend_r   <= 1'b1;
         rd_id_r     <= rd_idx_s;
      end else begin
         // Idle cycle: the address and data keep their old values, so the port only toggles on real accesses.
         gnt         <= {N_REQ{1'b0}};
         mem_we      <= 1'b0;
         rd_pend_r   <= 1'b0;
      end
   end

   // Response stage: line up the read tag with the BRAM's one-cycle read data.
   always_ff @(posedge vga_pix_clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= {ID_W{1'b0}};
      end else begin
         rsp_valid <= rd_pend_r;
         if (rd_pend_r) begin
            rsp_id <= rd_id_r;
         end
      end
   end

   assign rsp_data = mem_rdata;

endmodule

// File: tb/tb_map_port_arbiter.sv
module tb_map_port_arbiter;

   localparam int N  = 6;
   localparam int AW = 11;
   localparam int DW = 4;
   localparam logic [DW-1:0] EMPTY_TILE = 4'h0;

   logic              vga_pix_clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req;
   logic [N-1:0]      req_we;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_wdata;
   logic [N-1:0]      gnt;
   logic [AW-1:0]     mem_addr;
   logic              mem_we;
   logic [DW-1:0]     mem_wdata;
   logic [DW-1:0]     mem_rdata;
   logic              rsp_valid;
   logic [2:0]        rsp_id;
   logic [DW-1:0]     rsp_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 vga_pix_clk = ~vga_pix_clk;

   map_port_arbiter dut (
      .vga_pix_clk (vga_pix_clk),
      .rst         (rst),
      .req         (req),
      .req_we      (req_we),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .gnt         (gnt),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_data    (rsp_data)
   );

   // BRAM port B model: one-cycle synchronous read
   logic [DW-1:0] bram [0:2047];
   always @(posedge vga_pix_clk) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      mem_rdata <= bram[mem_addr];
   end

   // Reference model: memory contents as seen in grant order, plus the arbitration rules
   logic [DW-1:0] shadow [0:2047];
   int            m_rr = 0;
   int            m_streak = 0;
   bit            p1_v = 1'b0;
   int            p1_id = 0;
   logic [DW-1:0] p1_data;
   logic [N-1:0]  exp_gnt = '0;
   logic          exp_we = 1'b0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_wdata = '0;
   bit            exp_rv = 1'b0;
   int            exp_rid = 0;
   logic [DW-1:0] exp_rdata;

   task automatic set_req(input int idx, input bit we, input int addr, input logic [DW-1:0] data);
      req[idx]                = 1'b1;
      req_we[idx]             = we;
      req_addr[idx*AW +: AW]  = AW'(addr);
      req_wdata[idx*DW +: DW] = data;
   endtask

   task automatic clear_req();
      req    = '0;
      req_we = '0;
   endtask

   // Advance one clock and move the model across the same edge.
   task automatic tick();
      int win;
      int j;
      bit any_r;
      bit is_wr;
      logic [N-1:0] one;
      one = 6'b000001;
      @(posedge vga_pix_clk);
      if (rst) begin
         m_rr = 0; m_streak = 0; p1_v = 1'b0;
         exp_gnt = '0; exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rv = 1'b0;
      end else begin
         exp_rv = p1_v;
         if (p1_v) begin exp_rid = p1_id; exp_rdata = p1_data; end
         p1_v  = 1'b0;
         win   = -1;
         any_r = 1'b0;
         is_wr = 1'b0;
         for (int i = 0; i < N; i++) if (req[i] && !req_we[i]) any_r = 1'b1;
         for (int i = 0; i < N; i++) if (req[i] && req_we[i] && win < 0) win = i;
         if (win >= 0 && (!any_r || m_streak < 2)) begin
            is_wr    = 1'b1;
            m_streak = any_r ? m_streak + 1 : 0;
         end else begin
            win = -1;
            if (any_r) begin
               for (int k = 0; k < N; k++) begin
                  j = (m_rr + k) % N;
                  if (win < 0 && req[j] && !req_we[j]) win = j;
               end
               m_rr     = (win + 1) % N;
               m_streak = 0;
            end
         end
         if (win >= 0) begin
            exp_gnt  = one << win;
            exp_we   = is_wr;
            exp_addr = req_addr[win*AW +: AW];
            if (is_wr) begin
               exp_wdata        = req_wdata[win*DW +: DW];
               shadow[exp_addr] = exp_wdata;
            end else begin
               p1_v    = 1'b1;
               p1_id   = win;
               p1_data = shadow[exp_addr];
            end
         end else begin
            exp_gnt = '0;
            exp_we  = 1'b0;
         end
      end
      @(negedge vga_pix_clk);
   endtask

   task automatic preload(input int addr, input logic [DW-1:0] data);
      clear_req();
      set_req(5, 1'b1, addr, data);
      tick();
      clear_req();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_req();
      req_addr = '0; req_wdata = '0;
      tick(); tick();
      n_checks++; if (gnt !== 6'b000000) begin n_fail++; $display("FAIL reset_gnt: got %b want 000000", gnt); end
      n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", mem_we); end
      n_checks++; if (mem_addr !== 11'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
      n_checks++; if (mem_wdata !== 4'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", mem_wdata); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rv: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_id !== 3'd0) begin n_fail++; $display("FAIL reset_rid: got %0d want 0", rsp_id); end
      rst = 1'b0;
   endtask

   task automatic test_single_read();
      for (int a = 0; a < 16; a++) preload(a, 4'($urandom_range(0, 15)));
      preload(33, 4'h2);
      preload(70, 4'h7);
      preload(71, 4'h9);
      tick();
      set_req(0, 1'b0, 33, 4'h0);
      tick();
      clear_req();
      n_checks++; if (gnt !== 6'b000001) begin n_fail++; $display("FAIL single_gnt: got %b want 000001", gnt); end
      n_checks++; if (mem_addr !== 11'd33 || mem_we !== 1'b0) begin n_fail++; $display("FAIL single_addr: got %0d/we%b want 33/we0", mem_addr, mem_we); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early: got rv=%b want 0", rsp_valid); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_data !== 4'h2) begin
         n_fail++; $display("FAIL single_rsp: got v%b id%0d d%h want v1 id0 d2", rsp_valid, rsp_id, rsp_data); end
      tick();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got rv=%b want 0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      int seq[8] = '{1, 2, 3, 4, 1, 2, 3, 4};
      logic [N-1:0] one;
      one = 6'b000001;
      for (int i = 1; i <= 4; i++) set_req(i, 1'b0, i, 4'h0);
      for (int k = 0; k < 8; k++) begin
         tick();
         n_checks++; if (gnt !== (one << seq[k])) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, gnt, one << seq[k]); end
         if (k >= 1) begin
            n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'(seq[k-1]) || rsp_data !== exp_rdata) begin
               n_fail++; $display("FAIL rr_rsp[%0d]: got v%b id%0d d%h want v1 id%0d d%h", k, rsp_valid, rsp_id, rsp_data, seq[k-1], exp_rdata); end
         end
      end
      clear_req();
      tick(); tick();
   endtask

   task automatic test_write_priority();
      set_req(5, 1'b1, 70, EMPTY_TILE);
      set_req(0, 1'b0, 70, 4'h0);
      tick();
      n_checks++; if (gnt !== 6'b100000 || mem_we !== 1'b1 || mem_addr !== 11'd70 || mem_wdata !== EMPTY_TILE) begin
         n_fail++; $display("FAIL wp_write: got g%b we%b a%0d d%h want g100000 we1 a70 d0", gnt, mem_we, mem_addr, mem_wdata); end
      req[5] = 1'b0;
      tick();
      n_checks++; if (gnt !== 6'b000001 || mem_we !== 1'b0) begin n_fail++; $display("FAIL wp_read: got g%b we%b want g000001 we0", gnt, mem_we); end
      clear_req();
      tick();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_data !== EMPTY_TILE) begin
         n_fail++; $display("FAIL wp_rsp: got v%b id%0d d%h want v1 id0 d0", rsp_valid, rsp_id, rsp_data); end
      tick();
   endtask

   task automatic test_streak();
      int seq[9] = '{5, 5, 2, 5, 5, 2, 5, 5, 2};
      logic [N-1:0] one;
      one = 6'b000001;
      set_req(5, 1'b1, 71, 4'h5);
      set_req(2, 1'b0, 2, 4'h0);
      for (int k = 0; k < 9; k++) begin
         tick();
         n_checks++; if (gnt !== (one << seq[k])) begin n_fail++; $display("FAIL streak_gnt[%0d]: got %b want %b", k, gnt, one << seq[k]); end
         n_checks++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL streak_rv[%0d]: got %b want %b", k, rsp_valid, exp_rv); end
      end
      clear_req();
   endtask

   task automatic test_idle();
      tick(); tick();
      for (int k = 0; k < 10; k++) begin
         tick();
         n_checks++; if (gnt !== 6'b000000 || mem_we !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL idle[%0d]: got g%b we%b rv%b want all 0", k, gnt, mem_we, rsp_valid); end
      end
      for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 4'h0);
      tick();
      n_checks++; if (gnt !== 6'b001000) begin n_fail++; $display("FAIL idle_rrptr: got %b want 001000", gnt); end
      clear_req();
      tick(); tick();
   endtask

   task automatic test_reset_midflight();
      set_req(1, 1'b0, 1, 4'h0);
      tick();
      clear_req();
      n_checks++; if (gnt !== 6'b000010) begin n_fail++; $display("FAIL mid_gnt: got %b want 000010", gnt); end
      rst = 1'b1;
      tick();
      n_checks++; if (gnt !== 6'b000000 || mem_we !== 1'b0 || mem_addr !== 11'd0 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst: got g%b we%b a%0d rv%b want g0 we0 a0 rv0", gnt, mem_we, mem_addr, rsp_valid); end
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_norsp[%0d]: got %b want 0", k, rsp_valid); end
      end
      for (int i = 0; i < N; i++) set_req(i, 1'b0, i, 4'h0);
      tick();
      n_checks++; if (gnt !== 6'b000001) begin n_fail++; $display("FAIL mid_rr0: got %b want 000001", gnt); end
      clear_req();
      tick(); tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         clear_req();
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1)
               set_req(i, ($urandom_range(0, 2) == 0), $urandom_range(0, 15), 4'($urandom_range(0, 15)));
         end
         tick();
         n_checks++; if (gnt !== exp_gnt || mem_we !== exp_we) begin
            n_fail++; $display("FAIL rnd_gnt[%0d]: got g%b we%b want g%b we%b", c, gnt, mem_we, exp_gnt, exp_we); end
         if (exp_gnt != '0) begin
            n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", c, mem_addr, exp_addr); end
         end
         if (exp_we) begin
            n_checks++; if (mem_wdata !== exp_wdata) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, mem_wdata, exp_wdata); end
         end
         n_checks++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_rv[%0d]: got %b want %b", c, rsp_valid, exp_rv); end
         if (exp_rv) begin
            n_checks++; if (rsp_id !== 3'(exp_rid) || rsp_data !== exp_rdata) begin
               n_fail++; $display("FAIL rnd_rsp[%0d]: got id%0d d%h want id%0d d%h", c, rsp_id, rsp_data, exp_rid, exp_rdata); end
         end
      end
      rst = 1'b0;
      clear_req();
      tick();
   endtask

   initial begin
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0; rst = 1'b1;
      test_reset();
      test_single_read();
      test_round_robin();
      test_write_priority();
      test_streak();
      test_idle();
      test_reset_midflight();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
